pixel_issue_sequencer: RTL

Hardware source of pixel work for `fullModule`. It walks the screen raster in row-major order and presents each pixel coordinate to the ray marcher as `screen_x`/`screen_y` in Q11.21 with a one-cycle `valid_in` strobe. It holds one request outstanding and waits for the ray marcher's `valid_out` before issuing the next pixel. It checks the returned `sof`/`eol` markers against the raster position it issued, and reports frame progress and errors to the control/status registers.

---
 rtl/pixel_issue_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/pixel_issue_sequencer.sv
// Raster pixel issuer for the ray marcher: walks x/y in row-major order, keeps one
// request in flight, checks returned sof/eol markers and reports frame status.
module pixel_issue_sequencer #(
  parameter int unsigned H_RES          = 640,
  parameter int unsigned V_RES          = 480,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        continuous,
  input  logic        abort,
  output logic [31:0] screen_x,
  output logic [31:0] screen_y,
  output logic        valid_in,
  input  logic        ray_valid_out,
  input  logic        ray_sof,
  input  logic        ray_eol,
  output logic        busy,
  output logic        frame_done,
  output logic [18:0] pixel_count,
  output logic [15:0] frame_count,
  output logic        err_marker,
  output logic        err_timeout
);

  localparam int unsigned XW  = 10;
  localparam int unsigned YW  = 9;
  localparam int unsigned PCW = 19;
  localparam int unsigned FCW = 16;
  localparam int unsigned TW  = 32;
  localparam int unsigned CW  = 32;
  localparam int unsigned FRAC = 21;

  localparam logic [XW-1:0]  X_LAST = XW'(H_RES - 1);
  localparam logic [YW-1:0]  Y_LAST = YW'(V_RES - 1);
  localparam logic [PCW-1:0] PC_MAX = '1;
  localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_e;

  state_e         state_q, state_d;
  logic [XW-1:0]  x_q, x_d;
  logic [YW-1:0]  y_q, y_d;
  logic           exp_sof_q, exp_sof_d;
  logic           exp_eol_q, exp_eol_d;
  logic           abort_pend_q, abort_pend_d;
  logic [TW-1:0]  to_cnt_q, to_cnt_d;
  logic [CW-1:0]  sx_q, sx_d;
  logic [CW-1:0]  sy_q, sy_d;
  logic           valid_q, valid_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [PCW-1:0] pc_q, pc_d;
  logic [FCW-1:0] fc_q, fc_d;
  logic           errm_q, errm_d;
  logic           errt_q, errt_d;
  logic           ret;
  logic           last_px;

  // State and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      x_q          <= '0;
      y_q          <= '0;
      exp_sof_q    <= 1'b0;
      exp_eol_q    <= 1'b0;
      abort_pend_q <= 1'b0;
      to_cnt_q     <= '0;
      sx_q         <= '0;
      sy_q         <= '0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pc_q         <= '0;
      fc_q         <= '0;
      errm_q       <= 1'b0;
      errt_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      x_q          <= x_d;
      y_q          <= y_d;
      exp_sof_q    <= exp_sof_d;
      exp_eol_q    <= exp_eol_d;
      abort_pend_q <= abort_pend_d;
      to_cnt_q     <= to_cnt_d;
      sx_q         <= sx_d;
      sy_q         <= sy_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pc_q         <= pc_d;
      fc_q         <= fc_d;
      errm_q       <= errm_d;
      errt_q       <= errt_d;
    end
  end

  // Next-state and output decode
  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    exp_sof_d    = exp_sof_q;
    exp_eol_d    = exp_eol_q;
    abort_pend_d = abort_pend_q;
    to_cnt_d     = to_cnt_q;
    sx_d         = sx_q;
    sy_d         = sy_q;
    valid_d      = 1'b0;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    pc_d         = pc_q;
    fc_d         = fc_q;
    errm_d       = errm_q;
    errt_d       = errt_q;
    ret          = 1'b0;
    last_px      = (x_q == X_LAST) && (y_q == Y_LAST);

    case (state_q)
      S_IDLE: begin
        // Returns arriving here belong to a cancelled request and are dropped silently
        if (start) begin
          x_d          = '0;
          y_d          = '0;
          pc_d         = '0;
          errm_d       = 1'b0;
          errt_d       = 1'b0;
          abort_pend_d = 1'b0;
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        exp_sof_d = (x_q == '0) && (y_q == '0);
        exp_eol_d = (x_q == X_LAST);
        to_cnt_d  = '0;
        state_d   = S_WAIT;
        if (abort) abort_pend_d = 1'b1;
        if (ray_valid_out) errm_d = 1'b1;
      end
      S_WAIT: begin
        if (abort) abort_pend_d = 1'b1;
        if (ray_valid_out) begin
          ret = 1'b1;
          if ((ray_sof != exp_sof_q) || (ray_eol != exp_eol_q)) errm_d = 1'b1;
          if (pc_q != PC_MAX) pc_d = pc_q + PCW'(1);
        end else if ((TIMEOUT_CYCLES != 0) && (to_cnt_q == TO_LAST)) begin
          ret    = 1'b1;
          errt_d = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
        if (ret) begin
          if (x_q == X_LAST) begin
            x_d = '0;
            y_d = y_q + YW'(1);
          end else begin
            x_d = x_q + XW'(1);
          end
          state_d = (last_px || abort_pend_q || abort) ? S_DONE : S_ISSUE;
        end
      end
      S_DONE: begin
        abort_pend_d = 1'b0;
        if (ray_valid_out) errm_d = 1'b1;
        if (!abort_pend_q) fc_d = fc_q + FCW'(1);
        if (continuous && !abort_pend_q) begin
          x_d     = '0;
          y_d     = '0;
          pc_d    = '0;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the state being entered
    if (state_d == S_ISSUE) begin
      valid_d = 1'b1;
      sx_d    = CW'(x_d) << FRAC;
      sy_d    = CW'(y_d) << FRAC;
    end
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
  end

  assign screen_x    = sx_q;
  assign screen_y    = sy_q;
  assign valid_in    = valid_q;
  assign busy        = busy_q;
  assign frame_done  = done_q;
  assign pixel_count = pc_q;
  assign frame_count = fc_q;
  assign err_marker  = errm_q;
  assign err_timeout = errt_q;

endmodule
